control_sumador_5bits: RTL and testbench

- Sequencing controller for the calculator's shared 5-bit ripple adder (sumador_5bits), which it instantiates.
- Captures operand A, then operand B, from the 5-bit switch bus on button strobes, holds them stable at the adder for a programmable settle time, and registers the 6-bit sum for display.
- Supports chained accumulation: after a result, a new operand is added to the previous result.
- Flags an error when the chained result no longer fits in 5 bits.

---
 rtl/control_sumador_5bits.sv | 160 ++++++++++++++++
 tb/tb_control_sumador_5bits.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sumador_5bits.sv
// Sequencing controller for the calculator's shared 5-bit ripple adder.
// Loads operand A then B from the switches, waits for the adder to settle,
// captures the 6-bit sum and supports chained accumulation with overflow flag.

// Purely combinational 5-bit ripple-carry adder with 6-bit result.
module sumador_5bits (
   input  logic [4:0] a,
   input  logic [4:0] b,
   output logic [5:0] x
);

   localparam int unsigned ANCHO = 5;

   logic [ANCHO:0] acarreo;

   // Ripple the carry bit by bit; the final carry becomes the result MSB.
   always_comb begin
      acarreo    = '0;
      x          = '0;
      for (int i = 0; i < ANCHO; i++) begin
         x[i]          = a[i] ^ b[i] ^ acarreo[i];
         acarreo[i+1]  = (a[i] & b[i]) | (acarreo[i] & (a[i] ^ b[i]));
      end
      x[ANCHO] = acarreo[ANCHO];
   end

endmodule

module control_sumador_5bits #(
   parameter int unsigned ESPERA    = 4,
   parameter int unsigned ANCHO_CNT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] dato,
   input  logic       btn_cargar,
   input  logic       btn_borrar,
   output logic [5:0] resultado,
   output logic [4:0] operando,
   output logic [1:0] estado,
   output logic       ocupado,
   output logic       error
);

   localparam int unsigned ANCHO_OP  = 5;
   localparam int unsigned ANCHO_RES = 6;

   typedef enum logic [1:0] {
      CARGA_A = 2'd0,
      CARGA_B = 2'd1,
      SUMA    = 2'd2,
      MUESTRA = 2'd3
   } estado_t;

   estado_t                est, est_nxt;
   logic [ANCHO_OP-1:0]    reg_a, reg_a_nxt;
   logic [ANCHO_OP-1:0]    reg_b, reg_b_nxt;
   logic [ANCHO_CNT-1:0]   cnt, cnt_nxt;
   logic [ANCHO_RES-1:0]   resultado_nxt;
   logic [ANCHO_OP-1:0]    operando_nxt;
   logic                   ocupado_nxt;
   logic                   error_nxt;
   logic [ANCHO_RES-1:0]   suma_c;

   // Adder fed only from the operand registers so it stays stable during SUMA.
   sumador_5bits u_sumador (
      .a (reg_a),
      .b (reg_b),
      .x (suma_c)
   );

   assign estado = est;

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         est       <= CARGA_A;
         reg_a     <= '0;
         reg_b     <= '0;
         cnt       <= '0;
         resultado <= '0;
         operando  <= '0;
         ocupado   <= 1'b0;
         error     <= 1'b0;
      end else begin
         est       <= est_nxt;
         reg_a     <= reg_a_nxt;
         reg_b     <= reg_b_nxt;
         cnt       <= cnt_nxt;
         resultado <= resultado_nxt;
         operando  <= operando_nxt;
         ocupado   <= ocupado_nxt;
         error     <= error_nxt;
      end
   end

   // Next-state and next-output logic; clear has priority over load.
   always_comb begin
      est_nxt       = est;
      reg_a_nxt     = reg_a;
      reg_b_nxt     = reg_b;
      cnt_nxt       = cnt;
      resultado_nxt = resultado;
      operando_nxt  = operando;
      error_nxt     = error;

      if (btn_borrar) begin
         est_nxt       = CARGA_A;
         reg_a_nxt     = '0;
         reg_b_nxt     = '0;
         cnt_nxt       = '0;
         resultado_nxt = '0;
         operando_nxt  = '0;
         error_nxt     = 1'b0;
      end else begin
         unique case (est)
            CARGA_A: begin
               if (btn_cargar) begin
                  reg_a_nxt    = dato;
                  operando_nxt = dato;
                  est_nxt      = CARGA_B;
               end
            end
            CARGA_B: begin
               if (btn_cargar) begin
                  reg_b_nxt    = dato;
                  operando_nxt = dato;
                  cnt_nxt      = ANCHO_CNT'(ESPERA - 1);
                  est_nxt      = SUMA;
               end
            end
            SUMA: begin
               if (cnt == '0) begin
                  resultado_nxt = suma_c;
                  est_nxt       = MUESTRA;
               end else begin
                  cnt_nxt = cnt - ANCHO_CNT'(1);
               end
            end
            MUESTRA: begin
               if (btn_cargar) begin
                  if (resultado[ANCHO_RES-1]) begin
                     error_nxt = 1'b1;
                  end else begin
                     reg_a_nxt    = resultado[ANCHO_OP-1:0];
                     reg_b_nxt    = dato;
                     operando_nxt = dato;
                     cnt_nxt      = ANCHO_CNT'(ESPERA - 1);
                     est_nxt      = SUMA;
                  end
               end
            end
            default: est_nxt = CARGA_A;
         endcase
      end

      ocupado_nxt = (est_nxt == SUMA);
   end

endmodule

// File: tb/tb_control_sumador_5bits.sv
// Self-checking bench for control_sumador_5bits: directed vector table,
// hand-written async-reset sequence and randomized run against a
// transaction-level reference model.
`timescale 1ns/1ps
module tb_control_sumador_5bits;

   localparam int unsigned ESPERA = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] dato = '0;
   logic       btn_cargar = 1'b0;
   logic       btn_borrar = 1'b0;
   logic [5:0] resultado;
   logic [4:0] operando;
   logic [1:0] estado;
   logic       ocupado;
   logic       error;

   int n_cmp = 0;
   int n_bad = 0;

   control_sumador_5bits #(.ESPERA(ESPERA), .ANCHO_CNT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dato       (dato),
      .btn_cargar (btn_cargar),
      .btn_borrar (btn_borrar),
      .resultado  (resultado),
      .operando   (operando),
      .estado     (estado),
      .ocupado    (ocupado),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       c;
      logic       b;
      logic [4:0] d;
      logic [5:0] res;
      logic [4:0] op;
      logic [1:0] st;
      logic       oc;
      logic       er;
   } vec_t;

   vec_t vecs[$];

   // Expected output snapshot in one packed word: {res, op, st, oc, er}.
   function automatic logic [14:0] pack(input logic [5:0] r, input logic [4:0] o,
                                        input logic [1:0] s, input logic oc, input logic er);
      return {r, o, s, oc, er};
   endfunction

   function automatic void add(input logic c, input logic b, input logic [4:0] d,
                               input logic [5:0] r, input logic [4:0] o,
                               input logic [1:0] s, input logic oc, input logic er);
      vec_t v;
      v.c = c; v.b = b; v.d = d; v.res = r; v.op = o; v.st = s; v.oc = oc; v.er = er;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int idx, input logic [14:0] exp);
      logic [14:0] act;
      act = pack(resultado, operando, estado, ocupado, error);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got res=%0d op=%0d st=%0d oc=%0b er=%0b, want res=%0d op=%0d st=%0d oc=%0b er=%0b",
                  name, idx, act[14:9], act[8:4], act[3:2], act[1], act[0],
                  exp[14:9], exp[8:4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   // One clock: drive strobes, take the edge, drop strobes, settle for sampling.
   task automatic apply(input logic c, input logic b, input logic [4:0] d);
      btn_cargar = c;
      btn_borrar = b;
      dato       = d;
      @(posedge clk);
      #1;
      btn_cargar = 1'b0;
      btn_borrar = 1'b0;
   endtask

   // Reference model: transaction view with a countdown to the result edge.
   int m_st, m_a, m_b, m_res, m_op, m_err, m_left;

   function automatic void model_clear();
      m_st = 0; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_err = 0; m_left = 0;
   endfunction

   function automatic void model_step(input logic c, input logic b, input int d);
      if (b) begin
         model_clear();
      end else if (m_st == 0) begin
         if (c) begin m_a = d; m_op = d; m_st = 1; end
      end else if (m_st == 1) begin
         if (c) begin m_b = d; m_op = d; m_left = ESPERA; m_st = 2; end
      end else if (m_st == 2) begin
         m_left = m_left - 1;
         if (m_left == 0) begin m_res = m_a + m_b; m_st = 3; end
      end else begin
         if (c) begin
            if (m_res > 31) m_err = 1;
            else begin
               m_a = m_res; m_b = d; m_op = d; m_left = ESPERA; m_st = 2;
            end
         end
      end
   endfunction

   function automatic logic [14:0] model_out();
      return pack(6'(m_res), 5'(m_op), 2'(m_st), (m_st == 2), m_err[0]);
   endfunction

   initial begin
      // Basic 5 + 9, with a cargar during SUMA that must be ignored.
      add(1,0,5,  0,5,1,0,0);
      add(1,0,9,  0,9,2,1,0);
      add(1,0,21, 0,9,2,1,0);
      add(0,0,21, 0,9,2,1,0);
      add(0,0,21, 0,9,2,1,0);
      add(0,0,21, 14,9,3,0,0);
      add(0,0,21, 14,9,3,0,0);
      add(0,1,21, 0,0,0,0,0);
      // Extreme operands 31 + 31.
      add(1,0,31, 0,31,1,0,0);
      add(1,0,31, 0,31,2,1,0);
      for (int i = 0; i < 3; i++) add(0,0,21, 0,31,2,1,0);
      add(0,0,21, 62,31,3,0,0);
      add(0,1,21, 0,0,0,0,0);
      // Accumulate 3+4=7, +10=17, +31=48, then overflow error.
      add(1,0,3,  0,3,1,0,0);
      add(1,0,4,  0,4,2,1,0);
      for (int i = 0; i < 3; i++) add(0,0,21, 0,4,2,1,0);
      add(0,0,21, 7,4,3,0,0);
      add(1,0,10, 7,10,2,1,0);
      for (int i = 0; i < 3; i++) add(0,0,21, 7,10,2,1,0);
      add(0,0,21, 17,10,3,0,0);
      add(1,0,31, 17,31,2,1,0);
      for (int i = 0; i < 3; i++) add(0,0,21, 17,31,2,1,0);
      add(0,0,21, 48,31,3,0,0);
      add(1,0,1,  48,31,3,0,1);
      add(0,0,21, 48,31,3,0,1);
      add(1,0,2,  48,31,3,0,1);
      add(0,1,21, 0,0,0,0,0);
      // Clear in the second SUMA cycle: 12 + 6 never lands.
      add(1,0,12, 0,12,1,0,0);
      add(1,0,6,  0,6,2,1,0);
      add(0,0,21, 0,6,2,1,0);
      add(0,1,21, 0,0,0,0,0);
      for (int i = 0; i < 5; i++) add(0,0,21, 0,0,0,0,0);
      // Clear and load together in CARGA_B: clear wins, then a fresh 3 + 4.
      add(1,0,2,  0,2,1,0,0);
      add(1,1,7,  0,0,0,0,0);
      add(1,0,3,  0,3,1,0,0);
      add(1,0,4,  0,4,2,1,0);
      for (int i = 0; i < 3; i++) add(0,0,21, 0,4,2,1,0);
      add(0,0,21, 7,4,3,0,0);
      add(0,1,21, 0,0,0,0,0);

      // Reset state.
      #2;
      check("reset_async", 0, pack(0,0,0,0,0));
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_state", 0, pack(0,0,0,0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].c, vecs[i].b, vecs[i].d);
         check("vec", i, pack(vecs[i].res, vecs[i].op, vecs[i].st, vecs[i].oc, vecs[i].er));
      end

      // Async reset mid-SUMA, between edges.
      apply(1,0,12);
      apply(1,0,6);
      apply(0,0,21);
      check("pre_async", 0, pack(0,6,2,1,0));
      #2 rst_n = 1'b0;
      #1;
      check("async_drop", 0, pack(0,0,0,0,0));
      #4;
      check("async_hold", 0, pack(0,0,0,0,0));
      #1 rst_n = 1'b1;
      apply(1,0,5);
      check("async_after", 0, pack(0,5,1,0,0));
      apply(0,1,0);

      // Randomized run against the reference model.
      model_clear();
      for (int i = 0; i < 3000; i++) begin
         logic c, b;
         logic [4:0] d;
         c = ($urandom_range(0, 99) < 35);
         b = ($urandom_range(0, 99) < 3);
         d = 5'($urandom_range(0, 31));
         apply(c, b, d);
         model_step(c, b, int'(d));
         check("rand", i, model_out());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
